// File: rtl/accum_group_8bit.sv
// rtl/accum_group_8bit.sv - sums groups of N unsigned 8-bit operands into 12-bit results
//
// Purpose: collects N input beats into a running sum, then presents the group
// sum on a valid/ready output until it is taken downstream.
//
// Ports:
//   clk        in   1   clock, rising edge
//   rst_n      in   1   asynchronous active-low reset
//   data_in    in   8   unsigned operand
//   valid_in   in   1   data_in valid
//   ready_in   out  1   block can accept data_in this cycle
//   data_out   out  12  unsigned group sum
//   valid_out  out  1   data_out valid
//   ready_out  in   1   downstream accepts data_out this cycle
module accum_group_8bit #(
  parameter int N = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  data_in,
  input  logic        valid_in,
  output logic        ready_in,
  output logic [11:0] data_out,
  output logic        valid_out,
  input  logic        ready_out
);

  typedef enum logic {COLLECT, PRESENT} state_t;

  localparam logic [3:0] LAST = 4'(N - 1);

  state_t      state, state_nx;
  logic [11:0] acc, acc_nx;
  logic [3:0]  cnt, cnt_nx;
  logic [11:0] data_out_nx;
  logic        valid_out_nx;

  logic        in_beat;
  logic        out_beat;
  logic [11:0] data_ext;

  // While a result is pending, new data may only enter on the same cycle the
  // result leaves, so the input side stalls exactly as long as the output does.
  assign ready_in = (state == COLLECT) ? 1'b1 : ready_out;
  assign in_beat  = valid_in & ready_in;
  assign out_beat = valid_out & ready_out;
  assign data_ext = {4'd0, data_in};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= COLLECT;
      acc       <= '0;
      cnt       <= '0;
      data_out  <= '0;
      valid_out <= 1'b0;
    end else begin
      state     <= state_nx;
      acc       <= acc_nx;
      cnt       <= cnt_nx;
      data_out  <= data_out_nx;
      valid_out <= valid_out_nx;
    end
  end

  always_comb begin
    state_nx     = state;
    acc_nx       = acc;
    cnt_nx       = cnt;
    data_out_nx  = data_out;
    valid_out_nx = valid_out;
    case (state)
      COLLECT: begin
        if (in_beat) begin
          if (cnt == LAST) begin
            data_out_nx  = acc + data_ext;
            acc_nx       = '0;
            cnt_nx       = '0;
            valid_out_nx = 1'b1;
            state_nx     = PRESENT;
          end else begin
            acc_nx = acc + data_ext;
            cnt_nx = cnt + 4'd1;
          end
        end
      end
      PRESENT: begin
        if (out_beat) begin
          valid_out_nx = 1'b0;
          state_nx     = COLLECT;
          // An input beat here implies an output beat; it opens the next group.
          if (in_beat) begin
            acc_nx = data_ext;
            cnt_nx = 4'd1;
          end
        end
      end
      default: state_nx = COLLECT;
    endcase
  end

endmodule
